// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memory_pkg
//  Description : Shared encodings for the memory-access pipeline stage:
//                load/store size codes, misalignment exception causes and
//                the bus-transaction FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package memory_pkg;

   // Load/store access size
   localparam logic [1:0] LS_BYTE = 2'd0;
   localparam logic [1:0] LS_HALF = 2'd1;
   localparam logic [1:0] LS_WORD = 2'd2;

   // Exception causes raised by this stage
   localparam logic [3:0] ECAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] ECAUSE_STORE_MISALIGNED = 4'd6;

   // Bus-transaction FSM
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

endpackage : memory_pkg
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_align
//  Description : Purely combinational data alignment for the memory stage.
//                Store side: alignment check, lane replication and byte
//                strobes from the current instruction. Load side: lane
//                extraction and sign/zero extension using the format that
//                was latched when the request was issued.
//  Ports       : addr/size/rs2      - current instruction address, size, data
//                aligned            - access is naturally aligned
//                wdata/wstrb        - replicated store data and byte strobes
//                ld_off/ld_size/ld_signed - latched load format
//                rdata              - raw bus read data
//                ld_data            - aligned, extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_align
   import memory_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic [31:0] rs2,
   output logic        aligned,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic [1:0]  ld_off,
   input  logic [1:0]  ld_size,
   input  logic        ld_signed,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] w_shift;

   // Store side: replicate the data across every lane it could land in so
   // the strobe alone selects the written bytes.
   always_comb begin
      aligned = 1'b1;
      wdata   = rs2;
      wstrb   = 4'b1111;
      case (size)
         LS_BYTE: begin
            aligned = 1'b1;
            wdata   = {4{rs2[7:0]}};
            wstrb   = 4'b0001 << addr[1:0];
         end
         LS_HALF: begin
            aligned = ~addr[0];
            wdata   = {2{rs2[15:0]}};
            wstrb   = 4'b0011 << addr[1:0];
         end
         LS_WORD: begin
            aligned = (addr[1:0] == 2'b00);
            wdata   = rs2;
            wstrb   = 4'b1111;
         end
         default: begin
            // Unused size code behaves like a word access
            aligned = (addr[1:0] == 2'b00);
            wdata   = rs2;
            wstrb   = 4'b1111;
         end
      endcase
   end

   // Load side: bring the addressed lane down to bit 0, then extend.
   assign w_shift = rdata >> {ld_off, 3'b000};

   always_comb begin
      ld_data = w_shift;
      case (ld_size)
         LS_BYTE: ld_data = {{24{ld_signed & w_shift[7]}},  w_shift[7:0]};
         LS_HALF: ld_data = {{16{ld_signed & w_shift[15]}}, w_shift[15:0]};
         default: ld_data = w_shift;
      endcase
   end

endmodule : mem_align
`default_nettype wire

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
//  Module      : memory
//  Description : Memory-access pipeline stage between execute and writeback.
//                Issues at most one valid/ready bus transaction per
//                instruction, aligns load data, builds store strobes, flags
//                misaligned accesses and registers results to writeback.
//  Ports       : clk, rstn            - clock, synchronous active-low reset
//                *_in                 - instruction slot from execute
//                stall, invalidate    - from the hazard unit
//                busy                 - transaction pending/outstanding
//                branch_out/_address  - redirect to fetch (combinational)
//                mem_*                - data-bus request/response
//                *_out, load_data     - registered slot to writeback
//  Revision    : 1.0 - initial release
// ============================================================================
module memory
   import memory_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc_in,
   input  logic [31:0] next_pc_in,
   input  logic [31:0] alu_data_in,
   input  logic [31:0] rs2_data_in,
   input  logic [31:0] csr_data_in,
   input  logic        branch_taken_in,
   input  logic        load_in,
   input  logic        store_in,
   input  logic [1:0]  load_store_size_in,
   input  logic        load_signed_in,
   input  logic [1:0]  write_select_in,
   input  logic [4:0]  rd_addr_in,
   input  logic [11:0] csr_addr_in,
   input  logic        mret_in,
   input  logic        wfi_in,
   input  logic        valid_in,
   input  logic [3:0]  ecause_in,
   input  logic        exception_in,
   input  logic        stall,
   input  logic        invalidate,
   output logic        busy,
   output logic        branch_out,
   output logic [31:0] branch_address,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] next_pc_out,
   output logic [31:0] alu_data_out,
   output logic [31:0] csr_data_out,
   output logic [31:0] load_data,
   output logic [1:0]  write_select_out,
   output logic [4:0]  rd_addr_out,
   output logic [11:0] csr_addr_out,
   output logic        mret_out,
   output logic        wfi_out,
   output logic        valid_out,
   output logic [3:0]  ecause_out,
   output logic        exception_out
);

   state_t      r_state;
   state_t      w_state_next;

   // Bus request registers, frozen for the life of a transaction
   logic [31:0] r_mem_addr;
   logic        r_mem_write;
   logic [31:0] r_mem_wdata;
   logic [3:0]  r_mem_wstrb;
   // Latched load format
   logic [1:0]  r_ld_off;
   logic [1:0]  r_ld_size;
   logic        r_ld_signed;
   logic        r_is_load;
   // Completed-but-stalled result and sticky invalidate
   logic        r_done;
   logic [31:0] r_buf;
   logic        r_kill;

   logic        w_aligned;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_ld_data;
   logic        w_memop;
   logic        w_access;
   logic        w_misalign;
   logic        w_issue;
   logic        w_complete;
   logic        w_load_out;
   logic [31:0] w_load_result;
   logic [31:0] w_load_data_next;

   mem_align u_align (
      .addr      (alu_data_in),
      .size      (load_store_size_in),
      .rs2       (rs2_data_in),
      .aligned   (w_aligned),
      .wdata     (w_wdata),
      .wstrb     (w_wstrb),
      .ld_off    (r_ld_off),
      .ld_size   (r_ld_size),
      .ld_signed (r_ld_signed),
      .rdata     (mem_rdata),
      .ld_data   (w_ld_data)
   );

   assign branch_out     = valid_in & ~exception_in & branch_taken_in;
   assign branch_address = alu_data_in;

   assign w_memop    = valid_in & ~exception_in & (load_in | store_in);
   assign w_misalign = w_memop & ~w_aligned;
   // r_done blocks re-issuing an instruction whose transaction already
   // finished while the stage was stalled.
   assign w_access   = w_memop & w_aligned & ~invalidate & ~r_done;

   assign mem_addr  = r_mem_addr;
   assign mem_write = r_mem_write;
   assign mem_wdata = r_mem_wdata;
   assign mem_wstrb = r_mem_wstrb;

   // ---------------------------------------------------------------- FSM --
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      mem_valid    = 1'b0;
      w_issue      = 1'b0;
      w_complete   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_access) begin
               busy = 1'b1;
               if (!stall) begin
                  w_issue      = 1'b1;
                  w_state_next = REQ;
               end
            end
         end
         REQ: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               w_complete   = 1'b1;
               w_state_next = IDLE;
            end else begin
               busy = 1'b1;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // --------------------------------------------------------- datapath ----
   assign w_load_out    = ~stall & ~busy;
   assign w_load_result = r_is_load ? w_ld_data : 32'h0;

   always_comb begin
      w_load_data_next = 32'h0;
      if (w_complete) begin
         w_load_data_next = w_load_result;
      end else if (r_done) begin
         w_load_data_next = r_buf;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_mem_addr  <= 32'h0;
         r_mem_write <= 1'b0;
         r_mem_wdata <= 32'h0;
         r_mem_wstrb <= 4'h0;
         r_ld_off    <= 2'b00;
         r_ld_size   <= 2'b00;
         r_ld_signed <= 1'b0;
         r_is_load   <= 1'b0;
         r_done      <= 1'b0;
         r_buf       <= 32'h0;
         r_kill      <= 1'b0;
      end else begin
         if (w_issue) begin
            r_mem_addr  <= {alu_data_in[31:2], 2'b00};
            r_mem_write <= store_in;
            r_mem_wdata <= w_wdata;
            r_mem_wstrb <= w_wstrb;
            r_ld_off    <= alu_data_in[1:0];
            r_ld_size   <= load_store_size_in;
            r_ld_signed <= load_signed_in;
            r_is_load   <= load_in;
         end
         if (w_complete) begin
            r_buf <= w_load_result;
         end
         if (w_load_out) begin
            r_done <= 1'b0;
         end else if (w_complete) begin
            r_done <= 1'b1;
         end
         // An invalidate seen mid-transaction kills the slot when it retires
         if (w_load_out) begin
            r_kill <= 1'b0;
         end else if (invalidate && (r_state == REQ || r_done)) begin
            r_kill <= 1'b1;
         end
      end
   end

   // ------------------------------------------------- writeback register --
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pc_out           <= 32'h0;
         next_pc_out      <= 32'h0;
         alu_data_out     <= 32'h0;
         csr_data_out     <= 32'h0;
         load_data        <= 32'h0;
         write_select_out <= 2'b00;
         rd_addr_out      <= 5'h0;
         csr_addr_out     <= 12'h0;
         mret_out         <= 1'b0;
         wfi_out          <= 1'b0;
         valid_out        <= 1'b0;
         ecause_out       <= 4'h0;
         exception_out    <= 1'b0;
      end else if (w_load_out) begin
         pc_out           <= pc_in;
         next_pc_out      <= next_pc_in;
         alu_data_out     <= alu_data_in;
         csr_data_out     <= csr_data_in;
         load_data        <= w_load_data_next;
         write_select_out <= write_select_in;
         rd_addr_out      <= rd_addr_in;
         csr_addr_out     <= csr_addr_in;
         mret_out         <= mret_in;
         wfi_out          <= wfi_in;
         valid_out        <= valid_in & ~invalidate & ~r_kill;
         exception_out    <= exception_in | w_misalign;
         if (w_misalign) begin
            ecause_out <= load_in ? ECAUSE_LOAD_MISALIGNED : ECAUSE_STORE_MISALIGNED;
         end else begin
            ecause_out <= ecause_in;
         end
      end
   end

endmodule : memory
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory
//  Description : Self-checking bench for the memory stage. Directed cases
//                followed by randomized instructions, each checked against
//                arithmetic expectations derived from the access rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in;
   logic        branch_taken_in, load_in, store_in, load_signed_in;
   logic [1:0]  load_store_size_in, write_select_in;
   logic [4:0]  rd_addr_in;
   logic [11:0] csr_addr_in;
   logic        mret_in, wfi_in, valid_in, exception_in, stall, invalidate;
   logic [3:0]  ecause_in;
   logic        busy, branch_out, mem_valid, mem_ready, mem_write;
   logic [31:0] branch_address, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] pc_out, next_pc_out, alu_data_out, csr_data_out, load_data;
   logic [1:0]  write_select_out;
   logic [4:0]  rd_addr_out;
   logic [11:0] csr_addr_out;
   logic        mret_out, wfi_out, valid_out, exception_out;
   logic [3:0]  ecause_out;

   int n_assert = 0;
   int n_fail   = 0;
   logic        prev_valid;
   logic [31:0] prev_ld;

   memory dut (
      .clk(clk), .rstn(rstn), .pc_in(pc_in), .next_pc_in(next_pc_in),
      .alu_data_in(alu_data_in), .rs2_data_in(rs2_data_in), .csr_data_in(csr_data_in),
      .branch_taken_in(branch_taken_in), .load_in(load_in), .store_in(store_in),
      .load_store_size_in(load_store_size_in), .load_signed_in(load_signed_in),
      .write_select_in(write_select_in), .rd_addr_in(rd_addr_in), .csr_addr_in(csr_addr_in),
      .mret_in(mret_in), .wfi_in(wfi_in), .valid_in(valid_in), .ecause_in(ecause_in),
      .exception_in(exception_in), .stall(stall), .invalidate(invalidate), .busy(busy),
      .branch_out(branch_out), .branch_address(branch_address), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .pc_out(pc_out), .next_pc_out(next_pc_out), .alu_data_out(alu_data_out),
      .csr_data_out(csr_data_out), .load_data(load_data), .write_select_out(write_select_out),
      .rd_addr_out(rd_addr_out), .csr_addr_out(csr_addr_out), .mret_out(mret_out),
      .wfi_out(wfi_out), .valid_out(valid_out), .ecause_out(ecause_out),
      .exception_out(exception_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: load value from raw read data, by plain arithmetic
   function automatic logic [31:0] model_load(input logic [31:0] rd, input int off,
                                              input logic [1:0] sz, input logic sgn);
      logic [31:0] sh;
      longint v;
      sh = rd >> (8 * off);
      if (sz == 2'd0) begin
         v = longint'(sh % 256);
         if (sgn && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = longint'(sh % 65536);
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = longint'(sh);
      end
      return 32'(v);
   endfunction

   // op: 0 = no memory op, 1 = load, 2 = store
   // d: REQ cycles before mem_ready; stall_n: stall cycles from completion;
   // inv_at: REQ cycle index carrying an invalidate pulse (-1 = none)
   task automatic run_op(input int op, input logic [1:0] sz, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic sgn, input logic exc,
                         input logic [31:0] rdata, input int d, input int stall_n,
                         input int inv_at);
      int          nbytes, off;
      logic        aligned, memop, acc, misal, killed;
      logic [31:0] e_wd, e_ld;
      logic [3:0]  e_st, e_cause;
      nbytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off     = int'(addr % 4);
      aligned = ((addr % nbytes) == 0);
      memop   = (op != 0) && !exc;
      acc     = memop && aligned;
      misal   = memop && !aligned;
      killed  = acc && (inv_at >= 0) && (inv_at <= d);
      e_wd    = (sz == 2'd0) ? (rs2 & 32'hFF) * 32'h01010101 :
                (sz == 2'd1) ? (rs2 & 32'hFFFF) * 32'h00010001 : rs2;
      e_st    = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << off) : 4'hF;
      e_ld    = (acc && op == 1) ? model_load(rdata, off, sz, sgn) : 32'h0;

      pc_in              = $urandom;
      next_pc_in         = pc_in + 32'd4;
      csr_data_in        = $urandom;
      rd_addr_in         = 5'($urandom);
      csr_addr_in        = 12'($urandom);
      write_select_in    = 2'($urandom);
      mret_in            = 1'($urandom);
      wfi_in             = 1'($urandom);
      ecause_in          = 4'($urandom);
      e_cause            = misal ? ((op == 1) ? 4'd4 : 4'd6) : ecause_in;
      branch_taken_in    = 1'($urandom);
      exception_in       = exc;
      load_in            = (op == 1);
      store_in           = (op == 2);
      load_store_size_in = sz;
      load_signed_in     = sgn;
      alu_data_in        = addr;
      rs2_data_in        = rs2;
      valid_in           = 1'b1;
      mem_ready          = 1'($urandom);   // ignored outside a request
      mem_rdata          = $urandom;
      #1;
      check("busy_accept", 32'(busy), 32'(acc));
      check("mem_valid_idle", 32'(mem_valid), 32'h0);
      check("branch_out", 32'(branch_out), 32'(!exc && branch_taken_in));
      step();
      if (acc) begin
         mem_ready = 1'b0;
         for (int k = 0; k <= d; k++) begin
            invalidate = (k == inv_at);
            if (k == d) begin
               mem_ready = 1'b1;
               mem_rdata = rdata;
               if (stall_n > 0) stall = 1'b1;
            end else begin
               mem_rdata = $urandom;
            end
            #1;
            check("mem_valid_req", 32'(mem_valid), 32'h1);
            check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            check("mem_write", 32'(mem_write), 32'(op == 2));
            check("mem_wstrb", 32'(mem_wstrb), 32'(e_st));
            if (op == 2) check("mem_wdata", mem_wdata, e_wd);
            check("busy_req", 32'(busy), 32'(k != d));
            step();
            invalidate = 1'b0;
         end
         mem_ready = 1'b0;
         for (int s = 0; s < stall_n; s++) begin
            #1;
            check("hold_valid", 32'(valid_out), 32'(prev_valid));
            check("hold_load", load_data, prev_ld);
            check("stall_no_reissue", 32'(mem_valid), 32'h0);
            check("stall_busy", 32'(busy), 32'h0);
            if (s == stall_n - 1) stall = 1'b0;
            step();
         end
      end
      check("valid_out", 32'(valid_out), 32'(!killed));
      check("load_data", load_data, e_ld);
      check("exception_out", 32'(exception_out), 32'(exc || misal));
      check("ecause_out", 32'(ecause_out), 32'(e_cause));
      check("pc_out", pc_out, pc_in);
      check("next_pc_out", next_pc_out, pc_in + 32'd4);
      check("alu_data_out", alu_data_out, addr);
      check("csr_data_out", csr_data_out, csr_data_in);
      check("rd_addr_out", 32'(rd_addr_out), 32'(rd_addr_in));
      prev_valid = !killed;
      prev_ld    = e_ld;
      valid_in   = 1'b0;
      load_in    = 1'b0;
      store_in   = 1'b0;
      exception_in = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      {pc_in, next_pc_in, alu_data_in, rs2_data_in, csr_data_in} = '0;
      {branch_taken_in, load_in, store_in, load_signed_in, mret_in, wfi_in} = '0;
      {load_store_size_in, write_select_in, rd_addr_in, csr_addr_in, ecause_in} = '0;
      {valid_in, exception_in, stall, invalidate, mem_ready} = '0;
      mem_rdata = 32'h0;
      repeat (3) step();
      check("rst_valid_out", 32'(valid_out), 32'h0);
      check("rst_mem_valid", 32'(mem_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_load_data", load_data, 32'h0);
      rstn = 1'b1;
      step();

      // Directed cases
      run_op(2, 2'd2, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1, 0, -1);
      run_op(1, 2'd0, 32'h103, 32'h0, 1'b1, 1'b0, 32'h80112233, 0, 0, -1);
      check("signed_byte_direct", load_data, 32'hFFFFFF80);
      run_op(1, 2'd1, 32'h102, 32'h0, 1'b0, 1'b0, 32'h80112233, 2, 0, -1);
      check("unsigned_half_direct", load_data, 32'h00008011);
      run_op(1, 2'd2, 32'h102, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, -1);
      check("misaligned_cause", 32'(ecause_out), 32'd4);
      run_op(2, 2'd1, 32'h201, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, -1);
      check("misaligned_store_cause", 32'(ecause_out), 32'd6);
      run_op(2, 2'd0, 32'h101, 32'h12345678, 1'b0, 1'b0, 32'h0, 5, 0, -1);
      run_op(2, 2'd2, 32'h300, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 3, 0, 1);
      run_op(1, 2'd2, 32'h304, 32'h0, 1'b0, 1'b0, 32'h5A5AA5A5, 1, 0, -1);
      run_op(1, 2'd1, 32'h40E, 32'h0, 1'b1, 1'b0, 32'h9ABC0000, 2, 3, -1);
      run_op(0, 2'd0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 0, 0, -1);
      run_op(1, 2'd2, 32'h600, 32'h0, 1'b0, 1'b1, 32'h0, 0, 0, -1);

      // Reset while a request is outstanding
      alu_data_in = 32'h700; rs2_data_in = 32'h11; load_store_size_in = 2'd2;
      store_in = 1'b1; valid_in = 1'b1; mem_ready = 1'b0;
      step();
      check("pre_reset_mem_valid", 32'(mem_valid), 32'h1);
      rstn = 1'b0; valid_in = 1'b0; store_in = 1'b0;
      step();
      check("reset_req_mem_valid", 32'(mem_valid), 32'h0);
      check("reset_req_busy", 32'(busy), 32'h0);
      check("reset_req_valid_out", 32'(valid_out), 32'h0);
      check("reset_req_pc_out", pc_out, 32'h0);
      check("reset_req_mem_addr", mem_addr, 32'h0);
      rstn = 1'b1;
      prev_valid = 1'b0;
      prev_ld    = 32'h0;

      // Randomized instructions
      for (int i = 0; i < 60; i++) begin
         int          op, d, sn, ia;
         logic [1:0]  sz;
         logic [31:0] a;
         op = int'($urandom_range(0, 2));
         sz = 2'($urandom_range(0, 2));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0)
            a = a & ~((sz == 2'd0) ? 32'h0 : (sz == 2'd1) ? 32'h1 : 32'h3);
         d  = int'($urandom_range(0, 4));
         sn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         ia = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, d)) : -1;
         run_op(op, sz, a, $urandom, 1'($urandom), ($urandom_range(0, 7) == 0),
                $urandom, d, sn, ia);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_memory
`default_nettype wire
